// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: edge-detects the byte-complete
// strobe and queues bytes in a first-word-fall-through FIFO with a valid/ready read port.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     rx_data,
  input  logic                 rx_done,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  input  logic                 clear_overflow,
  input  logic                 flush
);

  localparam logic [PTR_WIDTH:0] L_DEPTH = (PTR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_WIDTH-1:0] r_wrPtr;
  logic [PTR_WIDTH-1:0] r_rdPtr;
  logic [PTR_WIDTH:0]   r_count;
  logic                 r_rxDoneQ;
  logic                 r_overflow;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_wrEn;
  logic w_rdEn;
  logic w_drop;

  // A held strobe yields a single push; a full FIFO only accepts when it pops too.
  assign w_push  = rx_done & ~r_rxDoneQ;
  assign w_full  = (r_count == L_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & rd_ready;
  assign w_wrEn  = w_push & (~w_full | w_pop) & ~flush;
  assign w_rdEn  = w_pop & ~flush;
  assign w_drop  = w_push & w_full & ~w_pop & ~flush;

  assign rd_data  = r_mem[r_rdPtr];
  assign rd_valid = ~w_empty;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;

  always_ff @(posedge clock) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr] <= rx_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_rxDoneQ  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rxDoneQ <= rx_done;

      // A new drop outranks a clear request in the same cycle.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end

      if (flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_wrEn) begin
          r_wrPtr <= r_wrPtr + 1'b1;
        end
        if (w_rdEn) begin
          r_rdPtr <= r_rdPtr + 1'b1;
        end
        case ({w_wrEn, w_rdEn})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
